spi_slave: RTL and testbench

SPI responder (slave) for the SPI subsystem, running entirely in the `mclk` domain. It oversamples the externally driven `sclk`, `cs_n` and `mosi` pins and shifts data LSB-first in SPI mode 0 (sample on `sclk` rise, drive on `sclk` fall). It returns one receive byte per 8 `sclk` cycles. It drives `miso` from a single-entry transmit buffer loaded by local logic through a ready/load handshake.

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_sync.sv | 26 ++
 rtl/spi_slave.sv | 192 +++++++++++++++++++
 tb/tb_spi_slave.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI subsystem.
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_state_t;

  localparam int unsigned SPI_DATA_W      = 8;
  localparam int unsigned SPI_SYNC_STAGES = 2;
  localparam logic [7:0]  SPI_IDLE_FILL   = 8'h00;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
module spi_sync
  import spi_pkg::*;
#(
  parameter int unsigned STAGES    = SPI_SYNC_STAGES,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, LSB-first, fully in the mclk domain with oversampled pins
// and a single-entry transmit buffer.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_q, cs_q;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  // cs_n resets high so a deasserted select produces no edge after reset.
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(mclk), .reset(reset), .d(sclk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(mclk), .reset(reset), .d(cs_n), .q(cs_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(mclk), .reset(reset), .d(mosi), .q(mosi_s)
  );

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign cs_rise   = cs_s & ~cs_q;

  spi_state_t        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              tx_full_q, tx_full_d;
  logic              miso_q, miso_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              frame_err_q, frame_err_d;
  logic              und_pend_q, und_pend_d;
  logic              skip_fall_q, skip_fall_d;
  logic              load_shift;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_buf_d    = tx_buf_q;
    tx_full_d   = tx_full_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    und_pend_d  = und_pend_q;
    skip_fall_d = skip_fall_q;
    load_shift  = 1'b0;

    unique case (state_q)
      IDLE: begin
        miso_d      = 1'b0;
        und_pend_d  = 1'b0;
        skip_fall_d = 1'b0;
        if (cs_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          load_shift = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d     = IDLE;
          miso_d      = 1'b0;
          bit_cnt_d   = '0;
          und_pend_d  = 1'b0;
          skip_fall_d = 1'b0;
          frame_err_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          rx_shift_d = {mosi_s, rx_shift_q[DATA_W-1:1]};
          // An empty reload at a byte boundary is only an underrun once the next byte starts.
          if (und_pend_q) begin
            underrun_d = 1'b1;
            und_pend_d = 1'b0;
          end
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d   = rx_shift_d;
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            load_shift  = 1'b1;
            skip_fall_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          // The fall right after a reload must keep bit 0 of the fresh byte on miso.
          if (skip_fall_q) begin
            skip_fall_d = 1'b0;
          end else begin
            tx_shift_d = tx_shift_q >> 1;
            miso_d     = tx_shift_d[0];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_shift) begin
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = DATA_W'(SPI_IDLE_FILL);
        if (state_q == IDLE) begin
          underrun_d = 1'b1;
        end else begin
          und_pend_d = 1'b1;
        end
      end
      miso_d = tx_shift_d[0];
    end

    if (tx_load && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      und_pend_q  <= 1'b0;
      skip_fall_q <= 1'b0;
    end else begin
      sclk_q      <= sclk_s;
      cs_q        <= cs_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
      und_pend_q  <= und_pend_d;
      skip_fall_q <= skip_fall_d;
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = ~tx_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a master task drives frames, a monitor checks rx bytes.
module tb_spi_slave;

  logic       mclk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk, cs_n, mosi, miso;
  logic       tx_load, tx_ready, rx_valid, tx_underrun, frame_err, busy;
  logic [7:0] tx_data, rx_data;

  int vectors = 0, errors = 0;
  int und_cnt = 0, ferr_cnt = 0, exp_und = 0, exp_ferr = 0;
  logic [7:0] rx_exp[$];

  // Reference model of the transmit buffer and last received byte.
  bit         model_full;
  logic [7:0] model_buf, last_rx;

  logic [7:0] mosi_b[3];
  bit         reload_v[3];
  logic [7:0] reload_b[3];

  always #5 mclk = ~mclk;

  spi_slave dut (
    .mclk(mclk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_underrun(tx_underrun), .frame_err(frame_err), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    tx_data = b;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
    if (!model_full) begin
      model_full = 1'b1;
      model_buf  = b;
    end
  endtask

  task automatic transfer(output logic [7:0] v, output bit empty);
    empty      = !model_full;
    v          = model_full ? model_buf : 8'h00;
    model_full = 1'b0;
  endtask

  always @(negedge mclk) begin
    if (!reset) begin
      if (tx_underrun) und_cnt++;
      if (frame_err) ferr_cnt++;
      if (rx_valid) begin
        if (rx_exp.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL rx_valid_unexpected: got data %0h, expected no byte", rx_data);
        end else begin
          check("rx_data", rx_data, rx_exp.pop_front());
        end
      end
    end
  end

  // abort_bits != 0 cuts the last byte short; do_reset then resets instead of raising cs_n.
  task automatic run_frame(input int n, input int abort_bits, input bit do_reset);
    logic [7:0] cur, cap;
    bit emp, pend, full;
    int nb;
    cs_n = 1'b0;
    transfer(cur, emp);
    if (emp) exp_und++;
    pend = 1'b0;
    cyc(8);
    for (int i = 0; i < n; i++) begin
      full = !(i == n - 1 && abort_bits != 0);
      nb   = full ? 8 : abort_bits;
      if (pend) exp_und++;
      if (full) rx_exp.push_back(mosi_b[i]);
      cap = 8'h00;
      for (int b = 0; b < nb; b++) begin
        mosi = mosi_b[i][b];
        cyc(6);
        sclk   = 1'b1;
        cap[b] = miso;
        if (b == 3 && i == 0) check("tx_ready_in_frame", tx_ready, !model_full);
        if (b == 3 && reload_v[i]) begin
          load_byte(reload_b[i]);
          cyc(5);
        end else begin
          cyc(6);
        end
        sclk = 1'b0;
      end
      if (full) begin
        check("miso_byte", cap, cur);
        last_rx = mosi_b[i];
        transfer(cur, pend);
      end
    end
    cyc(6);
    if (do_reset) begin
      reset = 1'b1;
      cyc(2);
      check("rst_miso", miso, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_rx_valid", rx_valid, 0);
      cs_n = 1'b1;
      mosi = 1'b0;
      cyc(1);
      reset      = 1'b0;
      model_full = 1'b0;
      last_rx    = 8'h00;
      cyc(4);
    end else begin
      cs_n = 1'b1;
      if (abort_bits != 0) exp_ferr++;
      cyc(12);
    end
    check("busy_idle", busy, 0);
    check("miso_idle", miso, 0);
    check("underrun_count", und_cnt, exp_und);
    check("frame_err_count", ferr_cnt, exp_ferr);
    check("rx_outstanding", rx_exp.size(), 0);
    check("rx_data_held", rx_data, last_rx);
    check("tx_ready_end", tx_ready, !model_full);
  endtask

  initial begin
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    model_full = 1'b0; model_buf = 8'h00; last_rx = 8'h00;
    for (int i = 0; i < 3; i++) begin
      reload_v[i] = 1'b0;
      reload_b[i] = 8'h00;
    end
    cyc(3);
    check("reset_miso", miso, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_underrun", tx_underrun, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_busy", busy, 0);
    check("reset_tx_ready", tx_ready, 1);
    reset = 1'b0;
    cyc(5);

    // Reset after 3 bits of a frame.
    load_byte(8'h3C);
    mosi_b[0] = 8'hC3;
    run_frame(1, 3, 1'b1);

    // Single byte.
    load_byte(8'h3C);
    mosi_b[0] = 8'hA5;
    run_frame(1, 0, 1'b0);

    // Back-to-back bytes with an in-frame reload.
    load_byte(8'h11);
    mosi_b[0] = 8'hF0; mosi_b[1] = 8'h0F;
    reload_v[0] = 1'b1; reload_b[0] = 8'h22;
    run_frame(2, 0, 1'b0);
    reload_v[0] = 1'b0;

    // Underrun.
    mosi_b[0] = 8'h55;
    run_frame(1, 0, 1'b0);

    // Abort after 3 bits.
    mosi_b[0] = 8'h9A;
    run_frame(1, 3, 1'b0);

    // Load while full is ignored.
    load_byte(8'hB7);
    load_byte(8'h99);
    check("tx_ready_full", tx_ready, !model_full);
    mosi_b[0] = 8'h6E;
    run_frame(1, 0, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      int n, ab;
      n  = int'($urandom_range(1, 3));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int i = 0; i < 3; i++) begin
        mosi_b[i]   = 8'($urandom);
        reload_v[i] = 1'($urandom_range(0, 1));
        reload_b[i] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) load_byte(8'($urandom));
      if ($urandom_range(0, 3) == 0) load_byte(8'($urandom));
      run_frame(n, ab, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
